// File: rtl/etapa_pkg.sv
// Shared definitions for the inter-stage pipeline registers of the MIPS core.
package etapa_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Bundle widths per pipeline boundary
  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_DATA_W  = 136;
  localparam int IDEX_CTRL_W  = 16;
  localparam int EXMEM_DATA_W = 136;
  localparam int EXMEM_CTRL_W = 16;
  localparam int MEMWB_DATA_W = 72;
  localparam int MEMWB_CTRL_W = 16;

  // Control-field bit offsets inside the control bundle
  localparam int CTRL_BRANCH   = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_REGDST   = 5;
  localparam int CTRL_ALUSRC   = 6;
  localparam int CTRL_ALUOP    = 7;

endpackage

// File: rtl/pipe_entry.sv
// One bundle slot: data register with load enable plus a valid flag that can be
// cleared synchronously without touching the data.
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         vld_o
);

  logic [W-1:0] data_q;
  logic         vld_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      if (ld_i) data_q <= d_i;
      if (clr_i)     vld_q <= 1'b0;
      else if (ld_i) vld_q <= 1'b1;
    end
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/etapa_pipe_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble and
// an optional skid entry so that o_ready comes straight from a flop.
module etapa_pipe_reg
  import etapa_pkg::*;
#(
  parameter int DATA_W = 136,
  parameter int CTRL_W = 16,
  parameter bit SKID   = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_count
);

  localparam int W = DATA_W + CTRL_W;

  state_e         state_q, state_d;
  logic           accept, emit;
  logic           main_ld, main_clr, main_sel_skid, main_vld;
  logic           skid_ld, skid_clr, skid_vld;
  logic [W-1:0]   main_d, main_q, skid_q;

  // A bundle offered together with a flush is dropped, never accepted.
  assign accept = i_valid & o_ready & ~i_flush;
  assign emit   = o_valid & i_ready;

  always_comb begin
    state_d       = state_q;
    main_ld       = 1'b0;
    main_clr      = 1'b0;
    main_sel_skid = 1'b0;
    skid_ld       = 1'b0;
    skid_clr      = 1'b0;
    if (i_flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          main_ld = 1'b1;
          state_d = ST_ONE;
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_ld = 1'b1;
          end else if (accept) begin
            skid_ld = 1'b1;
            state_d = ST_FULL;
          end else if (emit) begin
            main_clr = 1'b1;
            state_d  = ST_EMPTY;
          end
        end
        ST_FULL: if (emit && skid_vld) begin
          main_ld       = 1'b1;
          main_sel_skid = 1'b1;
          skid_clr      = 1'b1;
          state_d       = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_EMPTY;
    else         state_q <= state_d;
  end

  assign main_d = main_sel_skid ? skid_q : {i_ctrl, i_data};

  pipe_entry #(.W(W)) u_main (
    .clk_i (i_clk),
    .rst_i (i_reset),
    .clr_i (main_clr),
    .ld_i  (main_ld),
    .d_i   (main_d),
    .q_o   (main_q),
    .vld_o (main_vld)
  );

  generate
    if (SKID) begin : g_skid
      pipe_entry #(.W(W)) u_skid (
        .clk_i (i_clk),
        .rst_i (i_reset),
        .clr_i (skid_clr),
        .ld_i  (skid_ld),
        .d_i   ({i_ctrl, i_data}),
        .q_o   (skid_q),
        .vld_o (skid_vld)
      );
      assign o_ready = (state_q != ST_FULL);
    end else begin : g_noskid
      // Without a skid slot FULL is unreachable: accept in ONE implies emit.
      assign skid_q   = '0;
      assign skid_vld = 1'b0;
      assign o_ready  = ~main_vld | i_ready;
      wire unused_skid = &{1'b0, skid_ld, skid_clr};
    end
  endgenerate

  assign o_valid = main_vld;
  assign o_data  = main_q[DATA_W-1:0];
  assign o_ctrl  = main_vld ? main_q[W-1:DATA_W] : '0;
  assign o_count = state_q;

endmodule
